pipeline_ctrl: RTL



---
 rtl/core_isa_pkg.sv | 9 +
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipe_mem_arb.sv | 72 +++++++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/core_isa_pkg.sv
// Core-wide ISA constants shared by every stage and controller.
package core_isa_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// Types and encodings private to the pipeline controller; opcodes come from core_isa_pkg.
package pipeline_ctrl_pkg;

  // Memory-port FSM encodings
  localparam logic [1:0] MEM_ST_IDLE = 2'd0;
  localparam logic [1:0] MEM_ST_WAIT = 2'd1;
  localparam logic [1:0] MEM_ST_ERR  = 2'd2;

  // Bundle of PC / pipeline-register enables produced each cycle
  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_en_t;

  // True when a decode source operand is read and names the given register
  function automatic logic src_hit(input logic uses, input logic [4:0] rs_num,
                                   input logic [4:0] rd_num);
    return uses && (rs_num == rd_num);
  endfunction

endpackage

// File: rtl/pipe_mem_arb.sv
// Data-memory request/acknowledge FSM with WAIT timeout; generates the pipeline freeze.
module pipe_mem_arb
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v_mem,
  input  logic mem_op_type,
  input  logic mem_ack,
  output logic freeze,
  output logic mem_req,
  output logic mem_err
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  // Next-state, timeout counting and freeze; an ack outside WAIT has no effect
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (v_mem && mem_op_type) begin
          freeze     = 1'b1;
          state_d    = MEM_ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_ST_WAIT: begin
        if (mem_ack) begin
          // Freeze drops in the ack cycle so the MEM instruction retires now
          state_d = MEM_ST_IDLE;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = MEM_ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
      end
      MEM_ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = MEM_ST_IDLE;
      end
    endcase
  end

  // State and WAIT-cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_req = (state_q == MEM_ST_WAIT);
  assign mem_err = (state_q == MEM_ST_ERR);

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencing: valid bits, register enables, hazards and stall count.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
  import core_isa_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [4:0]       id_rs_1_num,
  input  logic [4:0]       id_rs_2_num,
  input  logic             id_uses_rs_1,
  input  logic             id_uses_rs_2,
  input  logic [6:0]       ex_opcode,
  input  logic [4:0]       ex_rd_num,
  input  logic             ex_redirect,
  input  logic             mem_op_type,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             v_id,
  output logic             v_ex,
  output logic             v_mem,
  output logic             v_wb,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             v_id_q, v_id_d;
  logic             v_ex_q, v_ex_d;
  logic             v_mem_q, v_mem_d;
  logic             v_wb_q, v_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             freeze;
  logic             ld_hit;
  logic             redirect;
  logic             load_use;
  pipe_en_t         en;

  pipe_mem_arb #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .v_mem      (v_mem_q),
    .mem_op_type(mem_op_type),
    .mem_ack    (mem_ack),
    .freeze     (freeze),
    .mem_req    (mem_req),
    .mem_err    (mem_err)
  );

  // Hazard terms with priority freeze > redirect > load_use
  always_comb begin
    ld_hit   = v_ex_q && v_id_q && (ex_opcode == OPC_LOAD) && (ex_rd_num != 5'd0) &&
               (src_hit(id_uses_rs_1, id_rs_1_num, ex_rd_num) ||
                src_hit(id_uses_rs_2, id_rs_2_num, ex_rd_num));
    redirect = !freeze && v_ex_q && ex_redirect;
    load_use = !freeze && !redirect && ld_hit;
  end

  // PC and pipeline-register enables
  always_comb begin
    en = '0;
    if (freeze) begin
      en = '0;
    end else if (redirect) begin
      en = '{pc_en: 1'b1, pc_sel: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
             ex_mem_en: 1'b1, mem_wb_en: 1'b1};
    end else if (load_use) begin
      // Hold PC and IF/ID; ID/EX loads a bubble while older stages drain
      en = '{pc_en: 1'b0, pc_sel: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
             ex_mem_en: 1'b1, mem_wb_en: 1'b1};
    end else begin
      en = '{pc_en: 1'b1, pc_sel: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1,
             ex_mem_en: 1'b1, mem_wb_en: 1'b1};
    end
  end

  // Valid-bit advance; everything holds while frozen
  always_comb begin
    v_id_d  = v_id_q;
    v_ex_d  = v_ex_q;
    v_mem_d = v_mem_q;
    v_wb_d  = v_wb_q;
    if (!freeze) begin
      v_wb_d  = v_mem_q;
      v_mem_d = v_ex_q;
      v_ex_d  = (redirect || load_use) ? 1'b0 : v_id_q;
      v_id_d  = redirect ? 1'b0 : (load_use ? v_id_q : if_valid);
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((freeze || load_use) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Valid-bit and stall-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_id_q      <= 1'b0;
      v_ex_q      <= 1'b0;
      v_mem_q     <= 1'b0;
      v_wb_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      v_id_q      <= v_id_d;
      v_ex_q      <= v_ex_d;
      v_mem_q     <= v_mem_d;
      v_wb_q      <= v_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en     = en.pc_en;
  assign pc_sel    = en.pc_sel;
  assign if_id_en  = en.if_id_en;
  assign id_ex_en  = en.id_ex_en;
  assign ex_mem_en = en.ex_mem_en;
  assign mem_wb_en = en.mem_wb_en;
  assign v_id      = v_id_q;
  assign v_ex      = v_ex_q;
  assign v_mem     = v_mem_q;
  assign v_wb      = v_wb_q;
  assign stall_cnt = stall_cnt_q;

endmodule
